// File: rtl/random_gen_pkg.sv
// Shared constants for the random_gen LFSR block.
// Optional feature macro: RANDOM_GEN_LOCKUP_GUARD_EN (see random_gen.sv).
package random_gen_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef logic [DEFAULT_WIDTH-1:0] lfsr_t;

    // Taps at bits 7, 5, 4 and 3.
    localparam lfsr_t TAP_MASK     = 8'b1011_1000;
    localparam lfsr_t DEFAULT_SEED = 8'h80;

endpackage

// File: rtl/random_gen_lfsr_step.sv
// Combinational single-step Fibonacci LFSR: shift left, feed tap parity into bit 0.
module lfsr_step
    import random_gen_pkg::*;
#(
    parameter int unsigned       WIDTH = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0]  TAPS  = TAP_MASK
) (
    input  logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] next_state
);

    logic feedback;

    always_comb begin
        feedback   = ^(state & TAPS);
        next_state = {state[WIDTH-2:0], feedback};
    end

endmodule

// File: rtl/random_gen.sv
// One-shot LFSR random number generator: advances once per reset on the first request.
// Build option: define RANDOM_GEN_LOCKUP_GUARD_EN to avoid the all-zero LFSR state.
module random_gen
    import random_gen_pkg::*;
#(
    parameter int unsigned      WIDTH = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] SEED  = DEFAULT_SEED
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             generate_num,
    output logic [WIDTH-1:0] rand_num,
    output logic             generated
);

    logic [WIDTH-1:0] rand_q, rand_d;
    logic             generated_q, generated_d;
    logic [WIDTH-1:0] step_out;
    logic [WIDTH-1:0] step_value;

    lfsr_step #(
        .WIDTH (WIDTH),
        .TAPS  (TAP_MASK)
    ) u_lfsr_step (
        .state      (rand_q),
        .next_state (step_out)
    );

`ifdef RANDOM_GEN_LOCKUP_GUARD_EN
    // A zero seed would lock the LFSR, so start from 1 instead.
    localparam logic [WIDTH-1:0] RESET_VALUE =
        (SEED == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : SEED;

    assign step_value = (step_out == '0) ? RESET_VALUE : step_out;
`else
    localparam logic [WIDTH-1:0] RESET_VALUE = SEED;

    assign step_value = step_out;
`endif

    always_comb begin
        rand_d      = rand_q;
        generated_d = generated_q;
        if (generate_num && !generated_q) begin
            rand_d      = step_value;
            generated_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rand_q      <= RESET_VALUE;
            generated_q <= 1'b0;
        end else begin
            rand_q      <= rand_d;
            generated_q <= generated_d;
        end
    end

    assign rand_num  = rand_q;
    assign generated = generated_q;

endmodule

// File: tb/tb_random_gen.sv
// Self-checking bench for random_gen: directed steps plus randomized requests and resets.
module tb_random_gen;

    logic       clk;
    logic       reset;
    logic       generate_num;
    logic [7:0] rand_num;
    logic       generated;
    logic [7:0] rand_num_z;
    logic       generated_z;

    int checks;
    int errors;

    // Reference state for the default-seed and zero-seed instances.
    logic [7:0] m_val;
    logic       m_gen;
    logic [7:0] m_val_z;
    logic       m_gen_z;

    random_gen dut (
        .clk          (clk),
        .reset        (reset),
        .generate_num (generate_num),
        .rand_num     (rand_num),
        .generated    (generated)
    );

    random_gen #(
        .WIDTH (8),
        .SEED  (8'h00)
    ) dut_zero (
        .clk          (clk),
        .reset        (reset),
        .generate_num (generate_num),
        .rand_num     (rand_num_z),
        .generated    (generated_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Next value from the polynomial description: taps 7,5,4,3 XORed into bit 0 after a shift.
    function automatic logic [7:0] ref_next(input logic [7:0] v);
        int    taps [4] = '{7, 5, 4, 3};
        logic  fb;
        fb = 1'b0;
        foreach (taps[i]) fb = fb ^ v[taps[i]];
        return 8'((v << 1) | {7'd0, fb});
    endfunction

    function automatic logic [7:0] ref_reset_z();
`ifdef RANDOM_GEN_LOCKUP_GUARD_EN
        return 8'h01;
`else
        return 8'h00;
`endif
    endfunction

    function automatic logic [7:0] ref_next_z(input logic [7:0] v);
        logic [7:0] n;
        n = ref_next(v);
`ifdef RANDOM_GEN_LOCKUP_GUARD_EN
        if (n == 8'h00) n = ref_reset_z();
`endif
        return n;
    endfunction

    task automatic model_reset();
        m_val   = 8'h80;
        m_gen   = 1'b0;
        m_val_z = ref_reset_z();
        m_gen_z = 1'b0;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".rand"},   rand_num,           m_val);
        check({tag, ".gen"},    {7'd0, generated},  {7'd0, m_gen});
        check({tag, ".rand_z"}, rand_num_z,         m_val_z);
        check({tag, ".gen_z"},  {7'd0, generated_z}, {7'd0, m_gen_z});
    endtask

    // Drive at the falling edge, update the model at the rising edge, sample just after it.
    task automatic step(input logic r, input logic gn, input string tag);
        @(negedge clk);
        reset        = r;
        generate_num = gn;
        if (!r) model_reset();
        @(posedge clk);
        if (!reset) begin
            model_reset();
        end else if (generate_num) begin
            if (!m_gen) begin
                m_val = ref_next(m_val);
                m_gen = 1'b1;
            end
            if (!m_gen_z) begin
                m_val_z = ref_next_z(m_val_z);
                m_gen_z = 1'b1;
            end
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b0;
        generate_num = 1'b0;
        model_reset();

        // Reset for 3 cycles, then release and idle one cycle.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "in_reset");
        step(1'b1, 1'b0, "post_reset");
        check("seed_value", rand_num, 8'h80);

        // Single-cycle pulse: first value from seed 0x80 is 0x01.
        step(1'b1, 1'b1, "first_pulse");
        check("first_value", rand_num, 8'h01);
        step(1'b1, 1'b0, "after_pulse");

        // Second pulse and a long request: no further advance.
        step(1'b1, 1'b1, "second_pulse");
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, "held_high");
        step(1'b1, 1'b0, "held_release");
        check("sticky_value", rand_num, 8'h01);

        // Asynchronous reset between clock edges.
        @(posedge clk);
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        step(1'b1, 1'b0, "async_release");
        step(1'b1, 1'b1, "async_pulse");
        check("async_value", rand_num, 8'h01);

        // Request held through reset release: one advance on the first edge.
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, "reset_with_req");
        step(1'b1, 1'b1, "release_with_req");
        check("release_value", rand_num, 8'h01);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, "release_hold");

        // Randomized requests with occasional resets, some asserted mid-cycle.
        for (int i = 0; i < 300; i++) begin
            int unsigned pick;
            pick = $urandom_range(0, 15);
            if (pick == 0) begin
                step(1'b0, 1'(($urandom_range(0, 1))), "rand_reset");
            end else if (pick == 1) begin
                @(posedge clk);
                #($urandom_range(1, 4));
                reset = 1'b0;
                model_reset();
                #1;
                check_all("rand_async");
            end else begin
                step(1'b1, 1'(($urandom_range(0, 1))), "rand_step");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/random_gen.md
RANDOM_GEN -- requirements
Module: random_gen

Interface
- REQ-001: Parameter WIDTH, default 8, LFSR and output width; only 8 is required to be supported.
- REQ-002: Parameter SEED, default 8'h80, LFSR value loaded by reset.
- REQ-003: The port clk SHALL be an input, 1 bit wide, and is the single clock; all state updates on its rising edge.
- REQ-004: The port reset SHALL be an input, 1 bit wide, asynchronous active-low reset; 0 = in reset.
- REQ-005: The port generate_num SHALL be an input, 1 bit wide, request to produce one random number; sampled on the clk rising edge.
- REQ-006: The port rand_num SHALL be an output, WIDTH bits wide, registered LFSR state.
- REQ-007: The port generated SHALL be an output, 1 bit wide, registered sticky flag; 1 once a number has been produced since reset.

Function
- REQ-008: The generator SHALL be a Fibonacci LFSR: feedback = rand_num[7] ^ rand_num[5] ^ rand_num[4] ^ rand_num[3]; next state = {rand_num[6:0], feedback}.
- REQ-009: On a rising edge with generated==0 and generate_num==1, rand_num SHALL take the next state and generated SHALL become 1 on the same edge (1-cycle latency, both visible after that edge).
- REQ-010: With generated==1, rand_num SHALL hold regardless of generate_num; generated SHALL stay 1 until reset.
- REQ-011: With generate_num==0, rand_num and generated SHALL hold.
- REQ-012: generate_num held high for several cycles SHALL cause exactly one advance (first edge only).
- REQ-013: From seed 0x80 the first generated value SHALL be 0x01.
- REQ-014: No handshake beyond the request; generate_num needs no acknowledge and may be a single-cycle pulse.

Reset
- REQ-015: While reset==0, rand_num SHALL be SEED (0x80) and generated SHALL be 0, asynchronously, regardless of clk and generate_num.
- REQ-016: Reset asserted mid-operation SHALL discard the produced value; after release, the next accepted request SHALL again yield 0x01.
- REQ-017: generate_num asserted during reset SHALL be ignored; the first rising edge after release with generate_num==1 is accepted.

Configuration
- REQ-018: Macro RANDOM_GEN_LOCKUP_GUARD_EN defined: when the computed next state would be all-zero, rand_num SHALL load SEED instead, and if SEED is 0 the reset value SHALL be 8'h01; generated behaves identically.
- REQ-019: Macro undefined: no guard; the all-zero state (reachable only with SEED==0) is kept as is; default-seed behaviour is identical in both builds.

Structure
- REQ-020: Package random_gen_pkg SHALL hold the tap mask constant (8'b1011_1000), default seed constant (8'h80) and the default width constant.
- REQ-021: Sub-module lfsr_step SHALL be combinational, taking the current state and producing the next state with the tap mask; random_gen holds the registers and the sticky-flag control.

Verification
- REQ-022: Hold reset low for 3 cycles, release, wait 1 cycle -> rand_num==0x80, generated==0.
- REQ-023: 1-cycle generate_num pulse after reset -> next edge rand_num==0x01, generated==1.
- REQ-024: Second pulse, then generate_num held high for 5 cycles -> rand_num stays 0x01, generated stays 1.
- REQ-025: Assert reset asynchronously between clock edges mid-run -> outputs become 0x80/0 immediately; release, pulse -> 0x01/1.
- REQ-026: generate_num held high through reset release -> exactly one advance to 0x01 on the first post-release edge.
- REQ-027: With RANDOM_GEN_LOCKUP_GUARD_EN defined and SEED=0 -> reset value 0x01; pulse -> 0x02; without the macro and SEED=0 -> reset 0x00, pulse -> 0x00 with generated==1.
